// File: rtl/turn_signal_controller_pkg.sv
// Shared types and constants for the Thunderbird tail-light sequencer.
// Provides the 3-bit state encoding, lamp patterns and a lamp decode helper.
package turn_signal_controller_pkg;

  localparam int unsigned LAMP_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_HAZ  = 3'd7
  } state_t;

  localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;
  localparam logic [LAMP_W-1:0] LAMP_1   = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_2   = 3'b011;
  localparam logic [LAMP_W-1:0] LAMP_3   = 3'b111;

  typedef struct packed {
    logic [LAMP_W-1:0] l;
    logic [LAMP_W-1:0] r;
  } lamps_t;

  // Moore lamp pattern for a given state; anything unexpected is dark.
  function automatic lamps_t decode_lamps(input state_t s);
    lamps_t o;
    o = '{l: LAMP_OFF, r: LAMP_OFF};
    case (s)
      ST_L1:   o.l = LAMP_1;
      ST_L2:   o.l = LAMP_2;
      ST_L3:   o.l = LAMP_3;
      ST_R1:   o.r = LAMP_1;
      ST_R2:   o.r = LAMP_2;
      ST_R3:   o.r = LAMP_3;
      ST_HAZ:  o = '{l: LAMP_3, r: LAMP_3};
      default: o = '{l: LAMP_OFF, r: LAMP_OFF};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/turn_signal_controller_if.sv
// Switch inputs and lamp/tick outputs of the tail-light sequencer.
//   Left, Right, Haz : switch levels (asynchronous to the clock)
//   L_Out, R_Out     : lamp drives, bit0 innermost
//   Step_Tick        : one-cycle step enable
interface turn_signal_controller_if;
  logic       Left;
  logic       Right;
  logic       Haz;
  logic [2:0] L_Out;
  logic [2:0] R_Out;
  logic       Step_Tick;

  modport master (output Left, Right, Haz, input L_Out, R_Out, Step_Tick);
  modport slave  (input Left, Right, Haz, output L_Out, R_Out, Step_Tick);
endinterface

// File: rtl/turn_signal_controller_step_tick_gen.sv
// Step enable generator: free-running 0..DIV_COUNT-1 counter, tick on the last count.
//   Clk_In    : clock
//   Rst       : asynchronous active-high reset
//   Step_Tick : high for one cycle every DIV_COUNT cycles
module step_tick_gen #(
  parameter int unsigned DIV_COUNT = 50000000
) (
  input  logic Clk_In,
  input  logic Rst,
  output logic Step_Tick
);

  localparam int unsigned CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_COUNT - 1);

  logic [CNT_W-1:0] count;

  // Wrapping step counter.
  always_ff @(posedge Clk_In or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Masked by reset so DIV_COUNT=1 stays low while held in reset.
  assign Step_Tick = (count == LAST) && !Rst;

endmodule

// File: rtl/turn_signal_controller.sv
// Thunderbird tail-light sequencer: left/right chase and hazard flash, one step per tick.
//   Clk_In : board clock
//   Rst    : asynchronous active-high reset
//   bus    : switches in, lamps and step tick out (slave modport)
module turn_signal_controller
  import turn_signal_controller_pkg::*;
#(
  parameter int unsigned DIV_COUNT = 50000000
) (
  input  logic                     Clk_In,
  input  logic                     Rst,
  turn_signal_controller_if.slave  bus
);

  logic       tick;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic       left_s;
  logic       right_s;
  logic       hreq;
  state_t     state;
  state_t     state_nxt;
  lamps_t     lamps;
  lamps_t     lamps_nxt;

  step_tick_gen #(.DIV_COUNT(DIV_COUNT)) u_tick (
    .Clk_In    (Clk_In),
    .Rst       (Rst),
    .Step_Tick (tick)
  );

  // Two-flop synchronizer for {Haz, Right, Left}.
  always_ff @(posedge Clk_In or posedge Rst) begin
    if (Rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.Haz, bus.Right, bus.Left};
      sync2 <= sync1;
    end
  end

  assign left_s  = sync2[0];
  assign right_s = sync2[1];
  assign hreq    = sync2[2] | (sync2[0] & sync2[1]);

  // State and lamp registers; lamps load the decode of the next state.
  always_ff @(posedge Clk_In or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
      lamps <= '{l: LAMP_OFF, r: LAMP_OFF};
    end else begin
      state <= state_nxt;
      lamps <= lamps_nxt;
    end
  end

  // Next state: advance only on a tick; hazard request preempts a chase.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (hreq)         state_nxt = ST_HAZ;
          else if (left_s)  state_nxt = ST_L1;
          else if (right_s) state_nxt = ST_R1;
          else              state_nxt = ST_IDLE;
        end
        ST_L1:   state_nxt = hreq ? ST_HAZ : ST_L2;
        ST_L2:   state_nxt = hreq ? ST_HAZ : ST_L3;
        ST_L3:   state_nxt = hreq ? ST_HAZ : ST_IDLE;
        ST_R1:   state_nxt = hreq ? ST_HAZ : ST_R2;
        ST_R2:   state_nxt = hreq ? ST_HAZ : ST_R3;
        ST_R3:   state_nxt = hreq ? ST_HAZ : ST_IDLE;
        ST_HAZ:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode of the next state so lamps change on the same edge as the state.
  always_comb begin
    lamps_nxt = decode_lamps(state_nxt);
  end

  assign bus.L_Out     = lamps.l;
  assign bus.R_Out     = lamps.r;
  assign bus.Step_Tick = tick;

endmodule

// File: tb/tb_turn_signal_controller.sv
// Bench for turn_signal_controller (DIV_COUNT=4): directed scenarios then random switching,
// each cycle compared against a step/position reference model.
module tb_turn_signal_controller;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  turn_signal_controller_if bus ();

  turn_signal_controller #(.DIV_COUNT(DIV)) dut (
    .Clk_In (clk),
    .Rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset, two-deep input history, mode and chase position.
  int e;
  bit s1l, s1r, s1h, s2l, s2r, s2h;
  int mode;  // 0 dark, 1 left chase, 2 right chase, 3 hazard flash
  int pos;   // lamps lit in the current chase, 1..3

  function automatic logic [2:0] bar(input int n);
    return 3'((1 << n) - 1);
  endfunction

  function automatic logic [2:0] exp_l();
    if (mode == 3) return 3'b111;
    if (mode == 1) return bar(pos);
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_r();
    if (mode == 3) return 3'b111;
    if (mode == 2) return bar(pos);
    return 3'b000;
  endfunction

  task automatic model_reset();
    e = 0;
    {s1l, s1r, s1h, s2l, s2r, s2h} = '0;
    mode = 0;
    pos = 0;
  endtask

  task automatic model_edge();
    bit hreq;
    e++;
    if ((e % DIV) == 0) begin
      hreq = s2h | (s2l & s2r);
      if (mode == 3) mode = 0;
      else if (hreq) mode = 3;
      else if (mode == 0) begin
        if (s2l) begin mode = 1; pos = 1; end
        else if (s2r) begin mode = 2; pos = 1; end
      end
      else if (pos < 3) pos++;
      else mode = 0;
    end
    {s2l, s2r, s2h} = {s1l, s1r, s1h};
    {s1l, s1r, s1h} = {bus.Left, bus.Right, bus.Haz};
  endtask

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    bit t;
    t = (((e + 1) % DIV) == 0);
    chk("l_out", bus.L_Out, exp_l());
    chk("r_out", bus.R_Out, exp_r());
    chk("step_tick", {2'b00, bus.Step_Tick}, {2'b00, t});
  endtask

  // Advance n clock edges, checking outputs just after each edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  // Called just after an edge: pulse reset mid-cycle, confirm immediate darkness, release on negedge.
  task automatic mid_reset();
    #4;
    rst = 1'b1;
    #1;
    chk("rst_l_out", bus.L_Out, 3'b000);
    chk("rst_r_out", bus.R_Out, 3'b000);
    chk("rst_tick", {2'b00, bus.Step_Tick}, 3'b000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_left2(input string tag);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      cyc(1);
      reached = (mode == 1 && pos == 2);
    end
    checks++;
    assert (reached) else begin
      errors++;
      $error("FAIL %s: observed=timeout expected=L_Out 011 within 40 cycles", tag);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.Left  = 1'b0;
    bus.Right = 1'b0;
    bus.Haz   = 1'b0;
    model_reset();
    #12;
    chk("reset_l_out", bus.L_Out, 3'b000);
    chk("reset_r_out", bus.R_Out, 3'b000);
    chk("reset_tick", {2'b00, bus.Step_Tick}, 3'b000);
    #3;
    rst = 1'b0;

    // Idle: periodic tick, lamps dark.
    cyc(13);
    mid_reset();
    cyc(9);

    // Left held: 001, 011, 111, 000 repeating.
    bus.Left = 1'b1;
    cyc(34);
    bus.Left = 1'b0;
    cyc(8);

    // Right pulsed for five cycles after a reset: full sequence then dark.
    mid_reset();
    bus.Right = 1'b1;
    cyc(5);
    bus.Right = 1'b0;
    cyc(24);

    // Hazard raised during the left chase, then held.
    bus.Left = 1'b1;
    wait_left2("reach_l2_haz");
    bus.Haz = 1'b1;
    cyc(24);
    bus.Haz = 1'b0;
    bus.Left = 1'b0;
    cyc(12);

    // Left and right together behave as hazard.
    bus.Left = 1'b1;
    bus.Right = 1'b1;
    cyc(20);
    bus.Left = 1'b0;
    bus.Right = 1'b0;
    cyc(12);

    // Reset during the left chase, sequence restarts.
    bus.Left = 1'b1;
    wait_left2("reach_l2_rst");
    mid_reset();
    cyc(16);
    bus.Left = 1'b0;
    cyc(8);

    // Random switching with occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) bus.Left  = ~bus.Left;
      if ($urandom_range(7) == 0) bus.Right = ~bus.Right;
      if ($urandom_range(11) == 0) bus.Haz  = ~bus.Haz;
      if ($urandom_range(99) == 0) mid_reset();
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turn_signal_controller.md
Name: turn_signal_controller

Overview:
- Sequencer for the Thunderbird tail lights: six lamps, three per side (LA/LB/LC, RA/RB/RC).
- Runs entirely on the 50 MHz board clock.
- An internal divider produces a one-cycle step enable (1 Hz by default) instead of a derived clock.
- A Moore FSM advances one step per enable, driving the left/right chase sequences and hazard flashing from the switch inputs.

Parameters:
- DIV_COUNT, 50000000, clock cycles per step (≥1). Set to 4 in simulation.
- CNT_W, $clog2(DIV_COUNT) (min 1), step counter width. Derived, not overridden.

Ports:
- Clk_In  input  1  board clock, 50 MHz; all flops on rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- Left  input  1  left-turn switch, asynchronous to Clk_In.
- Right  input  1  right-turn switch, asynchronous.
- Haz  input  1  hazard switch, asynchronous.
- L_Out  output  3  left lamps; bit0=LA (innermost), bit1=LB, bit2=LC.
- R_Out  output  3  right lamps; bit0=RA (innermost), bit1=RB, bit2=RC.
- Step_Tick  output  1  one-cycle step enable, exported for debug and bench sync.

Behaviour:
- Reset (asynchronous, active-high, immediate on assertion):
  - step counter=0, synchronizer flops=0, state=IDLE.
  - L_Out=3'b000, R_Out=3'b000, Step_Tick=0.
- Input synchronization:
  - Left, Right, Haz each pass through a 2-flop synchronizer; the FSM sees only synced values.
  - Latency is 2 cycles. An input must be stable ≥3 cycles before a tick to be used at that tick.
- Step counter:
  - Counts 0..DIV_COUNT-1 then wraps to 0.
  - Step_Tick=1 combinationally while count==DIV_COUNT-1, else 0.
  - First tick is the DIV_COUNT-th cycle after reset release; period is exactly DIV_COUNT cycles.
  - DIV_COUNT=1 gives Step_Tick constantly 1 after reset.
- FSM: state changes only on a clock edge where Step_Tick=1; otherwise it holds.
  - Define hreq = Haz | (Left & Right), using synced inputs.
  - IDLE: if hreq -> HAZ; else if Left -> L1; else if Right -> R1; else stay IDLE.
  - L1->L2->L3->IDLE, and R1->R2->R3->IDLE. Sequences run to completion even if Left/Right drops.
  - hreq at a tick in L1..L3 or R1..R3 forces HAZ. Hazard has priority.
  - HAZ -> IDLE unconditionally, so hazards flash at half the step rate.
- Outputs: Moore decode, registered. They change on the same edge the state changes (next-state decode feeds the output flops).
  - IDLE 000/000.
  - L1 L=001, L2 L=011, L3 L=111, with R=000.
  - R1 R=001, R2 R=011, R3 R=111, with L=000.
  - HAZ 111/111.
- Reset mid-sequence: lamps go dark immediately and the counter restarts from 0.
- Unused state encodings recover to IDLE on the next tick, with outputs 000/000.

Decomposition:
- Shared include file (turn_signal_defs.vh) holds:
  - 3-bit state encodings: IDLE, L1, L2, L3, R1, R2, R3, HAZ.
  - Lamp pattern constants: LAMP_OFF, LAMP_1, LAMP_2, LAMP_3.
- One natural sub-module: step_tick_gen (parameter DIV_COUNT; ports Clk_In, Rst, Step_Tick). It is reused by other lab sequencers.
- The synchronizer and FSM stay in the top module.

Test Plan (DIV_COUNT=4; clock period 20 ns; Rst high 0–15 ns):
- Reset/tick: no inputs -> Step_Tick high in cycles 4, 8, 12, … (one cycle wide); outputs stay 000/000. Assert Rst mid-count -> counter 0, next tick 4 cycles after release.
- Left held from cycle 1 -> after successive ticks L_Out=001, 011, 111, 000, 001…; R_Out=000 throughout.
- Right pulsed high cycles 1–5 only -> R_Out=001, 011, 111, then 000 and stays 000 (sequence completes after release).
- Left held, Haz asserted when L_Out=011 -> next tick gives 111/111, following tick 000/000. With Haz still held: alternating 111/111 and 000/000 every tick.
- Left & Right together, Haz=0 -> identical to hazard: 111/111, 000/000 alternating.
- Reset mid-sequence: Left held, assert Rst while L_Out=011 -> L_Out=000 within the same cycle (asynchronous). After release, the sequence restarts at 001 on the 4th cycle.
